tdc_stream_tx: RTL and testbench
================================

# tdc_stream_tx

- Transmit side of the `roughData`/`wrEn` stream consumed by `hisBuilderFSM`.
- Captures one acquisition's worth of per-pixel TDC timestamps in parallel, then serializes them one pixel per cycle in fixed pixel order.
- Repeats for `ACQ_NUM` acquisitions per frame, inserting a programmable idle gap between acquisitions.
- Replaces the file-driven stimulus that currently feeds the histogram builder.

## Interface
- `NP`, default `` `Np ``: timestamp width in bits.
- `PIXEL_NUM`, default `` `PIXEL_NUM ``: pixels per acquisition (must be ≥ 1).
- `ACQ_NUM`, default `` `ACQ_NUM ``: acquisitions per frame (must be ≥ 1).
- `GAP_CYC`, default 4: idle cycles (`wrEn`=0) after each acquisition except the last (0 allowed).
- `clk`, in, 1: single clock, rising edge.
- `res`, in, 1: reset, synchronous and active-high.
- `tdcValid`, in, 1: parallel acquisition offered.
- `tdcReady`, out, 1: block can capture an acquisition.
- `tdcData`, in, `PIXEL_NUM*NP`: pixel p occupies bits `[p*NP +: NP]`.
- `tdcHit`, in, `PIXEL_NUM`: per-pixel hit flag.
- `wrEn`, out, 1: stream beat valid. Connects to `hisBuilderFSM.wrEn`.
- `data`, out, `NP`: stream timestamp. Connects to `hisBuilderFSM.data`.
- `pixIdx`, out, `$clog2(PIXEL_NUM)` (min 1): pixel index of the current beat.
- `acqIdx`, out, `$clog2(ACQ_NUM)` (min 1): acquisition index of the current beat.
- `frameDone`, out, 1: one-cycle pulse after the last beat of a frame.

## Operation
- States: `IDLE`, `SEND`, `GAP`, `WAIT`, `DONE`.
- **IDLE**
  - `tdcReady`=1 and `acqIdx`=0.
  - On `tdcValid&&tdcReady`: capture `tdcData`/`tdcHit`, then go to `SEND`.
- **SEND**
  - `tdcReady`=0, `wrEn`=1 every cycle, `pixIdx` counts 0..`PIXEL_NUM-1`.
  - `data` = captured timestamp for hit pixels; `NO_HIT` (all ones, 2^NP−1) for pixels whose `tdcHit`=0.
  - Every pixel slot is always emitted, because the builder assigns pixels by position.
  - After pixel `PIXEL_NUM-1`:
    - if `acqIdx`=`ACQ_NUM-1`: go to `DONE`;
    - else if `GAP_CYC`>0: go to `GAP`;
    - else go to `WAIT`.
- **GAP**
  - `wrEn`=0, `tdcReady`=0.
  - Counts `GAP_CYC` cycles, then goes to `WAIT`.
- **WAIT**
  - `tdcReady`=1.
  - On handshake: capture, increment `acqIdx`, go to `SEND`.
- **DONE**
  - `frameDone`=1 for exactly one cycle, then `IDLE`.
- `tdcValid` while `tdcReady`=0 is ignored. Data is neither captured nor queued.
- `pixIdx` wraps to 0 at the start of each `SEND`. `acqIdx` wraps to 0 in `IDLE`.
- `data` is held at 0 whenever `wrEn`=0.
- Reset (synchronous, any state, including mid-`SEND`):
  - next edge: state `IDLE`, `wrEn`=0, `data`=0, `pixIdx`=0, `acqIdx`=0, `frameDone`=0, `tdcReady`=1;
  - the capture register is cleared and any partial acquisition is discarded.

## Timing
- All outputs are registered.
- Handshake at edge k → pixel 0 beat valid in the cycle after edge k+1; pixel p is valid in the cycle after edge k+1+p.
- One acquisition occupies exactly `PIXEL_NUM` consecutive `wrEn` cycles with no bubbles.
- Inter-acquisition spacing is `GAP_CYC` idle cycles, plus at least 1 `WAIT` cycle, before the next handshake can occur.
- `frameDone` is asserted in the cycle immediately after the last beat of acquisition `ACQ_NUM-1`.
- `tdcReady` rises:
  - in the cycle after `DONE`, via `IDLE`;
  - in the cycle after the last `GAP` cycle.
- Boundary cases:
  - `PIXEL_NUM`=1: `SEND` lasts one cycle.
  - `ACQ_NUM`=1: `SEND` always exits to `DONE`.
  - Simultaneous `res` and `tdcValid`: reset wins, no capture.

## Structure
- Shared package `sifh_pkg` holds:
  - the `tx_state_t` enum;
  - `NO_HIT` as a function of `NP`;
  - the index-width helper.
- These are shared with `hisBuilderFSM`, which must decode `NO_HIT` identically.
- One natural sub-module, `tdc_shift_reg`:
  - parallel-load, shift-out register of `PIXEL_NUM` × (`NP`+1) bits, holding the timestamp plus the hit flag;
  - shifts one pixel per `SEND` cycle.
- The FSM and counters stay in `tdc_stream_tx`.

## Test plan
All scenarios use `NP`=10, `PIXEL_NUM`=6, `ACQ_NUM`=2, `GAP_CYC`=4.

1. Single frame, all hits.
   - Stimulus: acq0 = {108, 511, 1022, 1022, 200, 90}, acq1 = {511, 1023, 90, 90, 90, 90}.
   - Required: 12 beats in that order, `pixIdx` 0..5 twice, `acqIdx` 0 then 1, exactly 4 idle cycles between acquisitions, then one `frameDone` pulse.
2. Miss pixels.
   - Stimulus: acq0 `tdcHit`=6'b101010 with data {300, 500, 50, 1000, 48, 90}.
   - Required: `data` = {1023, 500, 1023, 1000, 1023, 90}.
3. Back-pressure.
   - Stimulus: hold `tdcValid` continuously from reset.
   - Required: captures occur only in `IDLE`/`WAIT`; the second capture lands exactly 1 cycle after `GAP` ends; no beat is duplicated or lost.
4. Reset mid-`SEND`.
   - Stimulus: assert `res` during pixel 3 of acq1.
   - Required: at the next edge all outputs are at reset values; the next frame restarts at `acqIdx`=0, `pixIdx`=0.
5. Zero gap.
   - Stimulus: `GAP_CYC`=0.
   - Required: `SEND` → `WAIT` directly; with `tdcValid` held high, acq1 pixel 0 follows acq0 pixel 5 after exactly 1 idle cycle.
6. Reset with simultaneous valid.
   - Stimulus: `res`=1 and `tdcValid`=1 in the same cycle.
   - Required: no capture, `wrEn` stays 0.

Source files
------------

// File: rtl/sifh_pkg.sv
// Definitions shared by the TDC stream transmitter and the histogram builder that consumes it.
// Both sides must agree on the NO_HIT code and on the index widths.
package sifh_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StGap,
    StWait,
    StDone
  } tx_state_t;

  localparam int unsigned MaxNp = 64;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-ones code for a pixel that did not fire; the consumer slices the low np bits.
  function automatic logic [MaxNp-1:0] no_hit(input int unsigned np);
    logic [MaxNp-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxNp; i++) begin
      if (i < np) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/tdc_shift_reg.sv
// Parallel-load / shift-out store for one acquisition: each slot is {hit, timestamp}.
// Slot 0 is always the next pixel to send.
module tdc_shift_reg
  import sifh_pkg::*;
#(
  parameter int unsigned NP        = 10,
  parameter int unsigned PIXEL_NUM = 6
) (
  input  logic                    i_clk,
  input  logic                    i_res,
  input  logic                    i_load,
  input  logic                    i_shift,
  input  logic [PIXEL_NUM*NP-1:0] i_data,
  input  logic [PIXEL_NUM-1:0]    i_hit,
  output logic [NP-1:0]           o_ts,
  output logic                    o_hit
);

  logic [PIXEL_NUM-1:0][NP:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_sr <= '0;
    end else if (i_load) begin
      for (int p = 0; p < int'(PIXEL_NUM); p++) begin
        r_sr[p] <= {i_hit[p], i_data[p*NP +: NP]};
      end
    end else if (i_shift) begin
      r_sr <= r_sr >> (NP + 1);
    end
  end

  assign o_ts  = r_sr[0][NP-1:0];
  assign o_hit = r_sr[0][NP];

endmodule

// File: rtl/tdc_stream_tx.sv
// Captures one parallel acquisition of per-pixel TDC timestamps and streams it one pixel per
// cycle to the histogram builder, ACQ_NUM acquisitions per frame with an idle gap between them.
`ifndef Np
`define Np 10
`endif
`ifndef PIXEL_NUM
`define PIXEL_NUM 6
`endif
`ifndef ACQ_NUM
`define ACQ_NUM 2
`endif

module tdc_stream_tx
  import sifh_pkg::*;
#(
  parameter int unsigned NP        = `Np,
  parameter int unsigned PIXEL_NUM = `PIXEL_NUM,
  parameter int unsigned ACQ_NUM   = `ACQ_NUM,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          tdcValid,
  output logic                          tdcReady,
  input  logic [PIXEL_NUM*NP-1:0]       tdcData,
  input  logic [PIXEL_NUM-1:0]          tdcHit,
  output logic                          wrEn,
  output logic [NP-1:0]                 data,
  output logic [idx_w(PIXEL_NUM)-1:0]   pixIdx,
  output logic [idx_w(ACQ_NUM)-1:0]     acqIdx,
  output logic                          frameDone
);

  localparam int unsigned PixW = idx_w(PIXEL_NUM);
  localparam int unsigned AcqW = idx_w(ACQ_NUM);
  localparam int unsigned GapW = idx_w(GAP_CYC + 1);

  localparam logic [MaxNp-1:0] NoHitW = no_hit(NP);
  localparam logic [NP-1:0]    NoHit  = NoHitW[NP-1:0];

  tx_state_t         r_state;
  logic              r_ready;
  logic              r_wr;
  logic              r_done;
  logic [NP-1:0]     r_data;
  logic [PixW-1:0]   r_pix_idx;
  logic [AcqW-1:0]   r_acq_idx;
  logic [PixW-1:0]   r_cnt;
  logic [GapW-1:0]   r_gap;

  logic              w_load;
  logic              w_shift;
  logic [NP-1:0]     w_ts;
  logic              w_hit;
  logic              w_last_pix;

  // Ready is only ever high in IDLE/WAIT, so it alone qualifies a capture.
  assign w_load     = r_ready & tdcValid & ~res;
  assign w_shift    = (r_state == StSend) & ~res;
  assign w_last_pix = (r_cnt == PixW'(PIXEL_NUM - 1));

  tdc_shift_reg #(
    .NP        (NP),
    .PIXEL_NUM (PIXEL_NUM)
  ) u_shift_reg (
    .i_clk   (clk),
    .i_res   (res),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (tdcData),
    .i_hit   (tdcHit),
    .o_ts    (w_ts),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_state   <= StIdle;
      r_ready   <= 1'b1;
      r_wr      <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_pix_idx <= '0;
      r_acq_idx <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
    end else begin
      r_wr   <= 1'b0;
      r_data <= '0;
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_acq_idx <= '0;
          if (w_load) begin
            r_state <= StSend;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end
        end
        StSend: begin
          r_wr      <= 1'b1;
          r_data    <= w_hit ? w_ts : NoHit;
          r_pix_idx <= r_cnt;
          r_cnt     <= r_cnt + PixW'(1);
          if (w_last_pix) begin
            r_cnt <= '0;
            if (r_acq_idx == AcqW'(ACQ_NUM - 1)) begin
              r_state <= StDone;
            end else if (GAP_CYC > 0) begin
              r_state <= StGap;
              r_gap   <= '0;
            end else begin
              r_state <= StWait;
              r_ready <= 1'b1;
            end
          end
        end
        StGap: begin
          r_gap <= r_gap + GapW'(1);
          if (r_gap == GapW'(GAP_CYC - 1)) begin
            r_state <= StWait;
            r_ready <= 1'b1;
          end
        end
        StWait: begin
          if (w_load) begin
            r_state   <= StSend;
            r_ready   <= 1'b0;
            r_cnt     <= '0;
            r_acq_idx <= r_acq_idx + AcqW'(1);
          end
        end
        StDone: begin
          r_done    <= 1'b1;
          r_state   <= StIdle;
          r_ready   <= 1'b1;
          r_acq_idx <= '0;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tdcReady  = r_ready;
  assign wrEn      = r_wr;
  assign data      = r_data;
  assign pixIdx    = r_pix_idx;
  assign acqIdx    = r_acq_idx;
  assign frameDone = r_done;

endmodule

// File: tb/tb_tdc_stream_tx.sv
// Bench for tdc_stream_tx: lane 0 uses a 4-cycle gap, lane 1 a zero gap. A timeline model
// schedules every expected output from each handshake; literal checks pin that model.
module tb_tdc_stream_tx;

  localparam int NP   = 10;
  localparam int PN   = 6;
  localparam int AN   = 2;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res_l  [2];
  logic             vld_l  [2];
  logic [PN*NP-1:0] dat_l  [2];
  logic [PN-1:0]    hit_l  [2];
  logic             rdy_o  [2];
  logic             wr_o   [2];
  logic             fd_o   [2];
  logic [NP-1:0]    data_o [2];
  logic [2:0]       pix_o  [2];
  logic [0:0]       acq_o  [2];

  tdc_stream_tx #(.NP(NP), .PIXEL_NUM(PN), .ACQ_NUM(AN), .GAP_CYC(4)) u_dut_gap4 (
    .clk(clk), .res(res_l[0]), .tdcValid(vld_l[0]), .tdcReady(rdy_o[0]),
    .tdcData(dat_l[0]), .tdcHit(hit_l[0]), .wrEn(wr_o[0]), .data(data_o[0]),
    .pixIdx(pix_o[0]), .acqIdx(acq_o[0]), .frameDone(fd_o[0])
  );

  tdc_stream_tx #(.NP(NP), .PIXEL_NUM(PN), .ACQ_NUM(AN), .GAP_CYC(0)) u_dut_gap0 (
    .clk(clk), .res(res_l[1]), .tdcValid(vld_l[1]), .tdcReady(rdy_o[1]),
    .tdcData(dat_l[1]), .tdcHit(hit_l[1]), .wrEn(wr_o[1]), .data(data_o[1]),
    .pixIdx(pix_o[1]), .acqIdx(acq_o[1]), .frameDone(fd_o[1])
  );

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = -1;

  // Expected timeline per lane, indexed by the cycle following posedge number cyc.
  logic          m_wr [2][MAXC];
  logic          m_rdy[2][MAXC];
  logic          m_fd [2][MAXC];
  logic          m_pchk[2][MAXC];
  logic          m_achk[2][MAXC];
  logic [NP-1:0] m_data[2][MAXC];
  int            m_pix[2][MAXC];
  int            m_acq[2][MAXC];
  // Observed outputs, for the literal checks.
  logic          l_wr [2][MAXC];
  logic          l_rdy[2][MAXC];
  logic          l_fd [2][MAXC];
  logic [NP-1:0] l_data[2][MAXC];
  int            l_pix[2][MAXC];
  int            l_acq[2][MAXC];

  bit chk_en[2];
  int next_acq[2];
  int n_cap[2];
  int cap_cyc[2][16];
  int bq[32];
  int nb;

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d @%0t: got %0d, expected %0d", nm, l, $time, act, exp);
    end
  endtask

  function automatic int gap_of(input int l);
    return (l == 0) ? 4 : 0;
  endfunction

  function automatic logic [PN*NP-1:0] pk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5);
    int v[6];
    logic [PN*NP-1:0] r;
    v = '{a0, a1, a2, a3, a4, a5};
    for (int p = 0; p < PN; p++) r[p*NP +: NP] = v[p][NP-1:0];
    return r;
  endfunction

  task automatic model_step(input int l, input int k);
    int a;
    int r;
    int c;
    bit last;
    if (k >= MAXC) return;
    if (res_l[l]) begin
      chk_en[l]   = 1'b1;
      next_acq[l] = 0;
      for (int i = k; i < MAXC; i++) begin
        m_wr[l][i] = 1'b0; m_data[l][i] = '0; m_fd[l][i] = 1'b0; m_rdy[l][i] = 1'b1;
        m_pchk[l][i] = 1'b0; m_achk[l][i] = 1'b0;
      end
      m_pchk[l][k] = 1'b1; m_achk[l][k] = 1'b1; m_pix[l][k] = 0; m_acq[l][k] = 0;
    end else if (chk_en[l] && k > 0 && m_rdy[l][k-1] && vld_l[l]) begin
      a    = next_acq[l];
      last = (a == AN - 1);
      if (n_cap[l] < 16) cap_cyc[l][n_cap[l]] = k;
      n_cap[l]++;
      for (int p = 0; p < PN; p++) begin
        c = k + 1 + p;
        if (c < MAXC) begin
          m_wr[l][c]   = 1'b1;
          m_data[l][c] = hit_l[l][p] ? dat_l[l][p*NP +: NP] : 10'h3ff;
          m_pix[l][c]  = p; m_acq[l][c] = a;
          m_pchk[l][c] = 1'b1; m_achk[l][c] = 1'b1;
        end
      end
      r = last ? k + PN + 1 : k + PN + gap_of(l);
      for (int i = k; i < MAXC; i++) m_rdy[l][i] = (i >= r);
      if (last) begin
        c = k + PN + 1;
        if (c < MAXC) begin
          m_fd[l][c] = 1'b1; m_achk[l][c] = 1'b1; m_acq[l][c] = 0;
        end
        next_acq[l] = 0;
      end else begin
        next_acq[l] = a + 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int l = 0; l < 2; l++) model_step(l, cyc);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 0 && cyc < MAXC) begin
        for (int l = 0; l < 2; l++) begin
          l_wr[l][cyc] = wr_o[l]; l_rdy[l][cyc] = rdy_o[l]; l_fd[l][cyc] = fd_o[l];
          l_data[l][cyc] = data_o[l]; l_pix[l][cyc] = int'(pix_o[l]);
          l_acq[l][cyc] = int'(acq_o[l]);
          if (chk_en[l]) begin
            chk("wrEn", l, wr_o[l], m_wr[l][cyc]);
            chk("data", l, data_o[l], m_data[l][cyc]);
            chk("tdcReady", l, rdy_o[l], m_rdy[l][cyc]);
            chk("frameDone", l, fd_o[l], m_fd[l][cyc]);
            if (m_pchk[l][cyc]) chk("pixIdx", l, pix_o[l], m_pix[l][cyc]);
            if (m_achk[l][cyc]) chk("acqIdx", l, acq_o[l], m_acq[l][cyc]);
          end
        end
      end
    end
  end

  task automatic collect(input int l, input int s, input int e);
    nb = 0;
    for (int c = s; c < e && c < MAXC; c++) begin
      if (l_wr[l][c] === 1'b1 && nb < 32) begin
        bq[nb] = c;
        nb++;
      end
    end
  endtask

  // Offers two acquisitions back to back with valid held, then waits for frameDone.
  task automatic run_frame(input int l, input logic [PN*NP-1:0] d0, input logic [PN-1:0] h0,
                           input logic [PN*NP-1:0] d1, input logic [PN-1:0] h1);
    int base;
    bit seen;
    base = n_cap[l];
    seen = 1'b0;
    vld_l[l] = 1'b1; dat_l[l] = d0; hit_l[l] = h0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (n_cap[l] - base >= 1) begin dat_l[l] = d1; hit_l[l] = h1; end
      if (n_cap[l] - base >= 2) vld_l[l] = 1'b0;
      if (fd_o[l] === 1'b1) seen = 1'b1;
    end
    chk("frame_done_seen", l, seen, 1);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int b0;
    int cnt;
    int cr;
    int exp1[12];
    int exp2[6];
    bit aborted;
    exp1 = '{108, 511, 1022, 1022, 200, 90, 511, 1023, 90, 90, 90, 90};
    exp2 = '{1023, 500, 1023, 1000, 1023, 90};
    for (int l = 0; l < 2; l++) begin
      res_l[l] = 1'b1; vld_l[l] = 1'b0; dat_l[l] = '0; hit_l[l] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 0, rdy_o[0], 1);
    chk("reset_wrEn", 0, wr_o[0], 0);
    res_l[0] = 1'b0;

    // Single frame, all hits, valid held (also exercises back-pressure).
    s = cyc; b0 = n_cap[0];
    run_frame(0, pk(108, 511, 1022, 1022, 200, 90), 6'h3f,
              pk(511, 1023, 90, 90, 90, 90), 6'h3f);
    collect(0, s, cyc);
    chk("t1_beats", 0, nb, 12);
    if (nb >= 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("t1_data", 0, l_data[0][bq[i]], exp1[i]);
        chk("t1_pix", 0, l_pix[0][bq[i]], i % 6);
        chk("t1_acq", 0, l_acq[0][bq[i]], i / 6);
      end
      chk("t1_idle_total", 0, bq[6] - bq[5] - 1, 5);
      cnt = 0; cr = -1;
      for (int c = bq[5] + 1; c < bq[6]; c++) begin
        if (!l_wr[0][c] && !l_rdy[0][c]) cnt++;
        if (cr < 0 && l_rdy[0][c]) cr = c;
      end
      chk("t1_idle_not_ready", 0, cnt, 4);
      chk("t1_cap2_after_gap", 0, cap_cyc[0][b0+1], cr + 1);
      chk("t1_first_latency", 0, bq[0], cap_cyc[0][b0] + 1);
      chk("t1_framedone_pos", 0, l_fd[0][bq[11]+1], 1);
      cnt = 0;
      for (int c = s; c < cyc; c++) if (l_fd[0][c]) cnt++;
      chk("t1_framedone_count", 0, cnt, 1);
    end

    // Miss pixels get the all-ones code.
    s = cyc;
    run_frame(0, pk(300, 500, 50, 1000, 48, 90), 6'b101010, pk(1, 2, 3, 4, 5, 6), 6'h3f);
    collect(0, s, cyc);
    chk("t2_beats", 0, nb, 12);
    if (nb >= 6) for (int i = 0; i < 6; i++) chk("t2_data", 0, l_data[0][bq[i]], exp2[i]);

    // Reset during pixel 3 of acquisition 1.
    vld_l[0] = 1'b1; dat_l[0] = pk(7, 8, 9, 10, 11, 12); hit_l[0] = 6'h3f;
    b0 = n_cap[0]; aborted = 1'b0;
    for (int i = 0; i < 100 && !aborted; i++) begin
      @(negedge clk);
      if (n_cap[0] - b0 >= 2) vld_l[0] = 1'b0;
      if (wr_o[0] === 1'b1 && acq_o[0] === 1'b1 && pix_o[0] === 3'd3) begin
        res_l[0] = 1'b1;
        aborted = 1'b1;
      end
    end
    chk("t4_reached_pixel3", 0, aborted, 1);
    @(negedge clk);
    res_l[0] = 1'b0; vld_l[0] = 1'b0;
    chk("t4_wrEn", 0, wr_o[0], 0);
    chk("t4_data", 0, data_o[0], 0);
    chk("t4_pix", 0, pix_o[0], 0);
    chk("t4_acq", 0, acq_o[0], 0);
    chk("t4_ready", 0, rdy_o[0], 1);
    chk("t4_done", 0, fd_o[0], 0);
    repeat (3) @(negedge clk);
    s = cyc;
    run_frame(0, pk(20, 21, 22, 23, 24, 25), 6'h3f, pk(30, 31, 32, 33, 34, 35), 6'h3f);
    collect(0, s, cyc);
    chk("t4_restart_beats", 0, nb, 12);
    if (nb >= 1) begin
      chk("t4_restart_pix", 0, l_pix[0][bq[0]], 0);
      chk("t4_restart_acq", 0, l_acq[0][bq[0]], 0);
      chk("t4_restart_data", 0, l_data[0][bq[0]], 20);
    end

    // Reset and valid together: reset wins.
    @(negedge clk);
    res_l[0] = 1'b1; vld_l[0] = 1'b1; dat_l[0] = pk(1, 1, 1, 1, 1, 1);
    @(negedge clk);
    res_l[0] = 1'b0; vld_l[0] = 1'b0;
    s = cyc;
    chk("t6_ready", 0, rdy_o[0], 1);
    repeat (10) @(negedge clk);
    collect(0, s, cyc);
    chk("t6_no_beats", 0, nb, 0);

    // Zero gap on lane 1.
    res_l[1] = 1'b0;
    @(negedge clk);
    s = cyc;
    run_frame(1, pk(1, 2, 3, 4, 5, 6), 6'h3f, pk(7, 8, 9, 10, 11, 12), 6'h3f);
    collect(1, s, cyc);
    chk("t5_beats", 1, nb, 12);
    if (nb >= 12) begin
      chk("t5_idle", 1, bq[6] - bq[5] - 1, 1);
      chk("t5_ready_at_last_beat", 1, l_rdy[1][bq[5]], 1);
      chk("t5_acq1_pix0", 1, l_data[1][bq[6]], 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
